// File: rtl/std_mem_d1_fill.sv
// std_mem_d1_fill: drains a valid/ready stream into addresses 0..len-1 of a
// single-port std_mem_d1, one write at a time, using a go/done handshake.
module std_mem_d1_fill #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SIZE     = 16,
  parameter int unsigned IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [IDX_SIZE:0]   len,
  output logic                done,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic [WIDTH-1:0]    mem_write_data,
  output logic                mem_write_en,
  input  logic                mem_done
);

  localparam int unsigned LenW = IDX_SIZE + 1;
  localparam logic [LenW-1:0] SizeLen = LenW'(SIZE);

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StWrite,
    StWait,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [LenW-1:0] len_q, len_d;
  logic [LenW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LenW-1:0] len_clamped;
  logic [LenW-1:0] idx_inc;

  // Requested length is clamped so no address at or beyond SIZE is ever written.
  always_comb begin
    len_clamped = (len > SizeLen) ? SizeLen : len;
    idx_inc     = idx_q + LenW'(1);
  end

  // Next-state and register updates; one element per ACCEPT/WRITE/WAIT round.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          len_d   = len_clamped;
          idx_d   = '0;
          state_d = (len_clamped == '0) ? StDone : StAccept;
        end
      end
      StAccept: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = StWrite;
        end
      end
      StWrite: begin
        state_d = StWait;
      end
      StWait: begin
        if (mem_done) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == len_q) ? StDone : StAccept;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Moore outputs: decoded from state, address/data straight from registers.
  always_comb begin
    done           = (state_q == StDone);
    in_ready       = (state_q == StAccept);
    mem_write_en   = (state_q == StWrite);
    mem_addr0      = idx_q[IDX_SIZE-1:0];
    mem_write_data = data_q;
  end

endmodule

// File: tb/tb_std_mem_d1_fill.sv
// Self-checking bench for std_mem_d1_fill: stream producer, std_mem_d1-style
// memory model with configurable done latency, and a write scoreboard.
module tb_std_mem_d1_fill;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned SIZE     = 16;
  localparam int unsigned IDX_SIZE = 4;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic                clk;
  logic                reset;
  logic                go;
  logic [IDX_SIZE:0]   len;
  logic                done;
  logic [WIDTH-1:0]    in_data;
  logic                in_valid;
  logic                in_ready;
  logic [IDX_SIZE-1:0] mem_addr0;
  logic [WIDTH-1:0]    mem_write_data;
  logic                mem_write_en;
  logic                mem_done;
  logic                force_done;

  int n_checks;
  int n_fail;
  int cyc;
  int t0;
  int mem_cnt;
  int mem_delay;
  int gap_cfg;
  int gap_cnt;
  int exp_addr;
  int beats;
  int rdy_n;
  int viol;
  bit waiting;

  logic [31:0] mem [SIZE];
  logic [31:0] src_q [$];
  wr_t         sb_q [$];
  int          done_q [$];
  int          wr_q [$];

  std_mem_d1_fill #(
    .WIDTH    (WIDTH),
    .SIZE     (SIZE),
    .IDX_SIZE (IDX_SIZE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .go             (go),
    .len            (len),
    .done           (done),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_addr0      (mem_addr0),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_done       (mem_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: write on write_en, done pulse mem_delay cycles later.
  always @(posedge clk) begin
    if (mem_write_en === 1'b1) begin
      mem[mem_addr0] <= mem_write_data;
      mem_cnt        <= mem_delay;
    end else if (mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end
  assign mem_done = (mem_cnt == 1) || force_done;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor and producer, mid-cycle: log events, check writes, drive the stream.
  always @(negedge clk) begin
    int  rel;
    wr_t e;
    rel = cyc - t0;
    if (done === 1'b1) done_q.push_back(rel);
    if (in_ready === 1'b1) rdy_n++;
    if (in_ready === 1'b1 && (mem_write_en === 1'b1 || done === 1'b1 || waiting)) viol++;
    if (mem_write_en === 1'b1) begin
      wr_q.push_back(rel);
      waiting = 1'b1;
      check_eq("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("wr_addr", 64'(mem_addr0), 64'(e.addr));
        check_eq("wr_data", 64'(mem_write_data), 64'(e.data));
      end
    end else if (mem_done) begin
      waiting = 1'b0;
    end
    if (in_ready === 1'b1 && src_q.size() > 0) begin
      if (gap_cnt > 0) begin
        gap_cnt--;
        in_valid = 1'b0;
        in_data  = $urandom();
      end else begin
        in_valid = 1'b1;
        in_data  = src_q.pop_front();
        sb_q.push_back('{addr: exp_addr[4:0], data: in_data});
        exp_addr++;
        beats++;
        gap_cnt  = gap_cfg;
      end
    end else begin
      in_valid = 1'b0;
      in_data  = $urandom();
      gap_cnt  = gap_cfg;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [4:0] l, input int n_data, input int gap, input int dly,
                            input int base);
    src_q.delete();
    for (int i = 0; i < n_data; i++) src_q.push_back(32'(base + i));
    done_q.delete();
    wr_q.delete();
    rdy_n     = 0;
    beats     = 0;
    viol      = 0;
    exp_addr  = 0;
    gap_cfg   = gap;
    mem_delay = dly;
    go        = 1'b1;
    len       = l;
    t0        = cyc;
    tick();
    go        = 1'b0;
    len       = 5'd1;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_q.size() == 0 && k < budget) begin
      tick();
      k++;
    end
    check_eq("done_seen", 64'(done_q.size() > 0), 64'd1);
  endtask

  function automatic int first_done();
    return (done_q.size() > 0) ? done_q[0] : -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    go         = 1'b0;
    len        = '0;
    force_done = 1'b0;
    mem_delay  = 1;
    repeat (3) tick();
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_write_en", 64'(mem_write_en), 64'd0);
    check_eq("rst_addr", 64'(mem_addr0), 64'd0);
    check_eq("rst_wdata", 64'(mem_write_data), 64'd0);
    reset = 1'b0;
    tick();

    // Basic fill
    start_xfer(5'd4, 4, 0, 1, 'hA);
    wait_done(40);
    repeat (2) tick();
    check_eq("basic_nwr", 64'(wr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("basic_wr_cyc", 64'((i < wr_q.size()) ? wr_q[i] : -1), 64'(2 + 3 * i));
      check_eq("basic_mem", 64'(mem[i]), 64'('hA + i));
    end
    check_eq("basic_ndone", 64'(done_q.size()), 64'd1);
    check_eq("basic_done_cyc", 64'(first_done()), 64'd13);
    check_eq("basic_viol", 64'(viol), 64'd0);

    // Backpressure and slow memory
    start_xfer(5'd3, 3, 2, 3, 'h50);
    wait_done(60);
    repeat (2) tick();
    check_eq("bp_done_cyc", 64'(first_done()), 64'd22);
    check_eq("bp_beats", 64'(beats), 64'd3);
    check_eq("bp_nwr", 64'(wr_q.size()), 64'd3);
    check_eq("bp_viol", 64'(viol), 64'd0);
    check_eq("bp_sb_empty", 64'(sb_q.size()), 64'd0);
    check_eq("bp_mem2", 64'(mem[2]), 64'h52);

    // Zero length
    start_xfer(5'd0, 0, 0, 1, 0);
    wait_done(10);
    repeat (3) tick();
    check_eq("zero_done_cyc", 64'(first_done()), 64'd1);
    check_eq("zero_ndone", 64'(done_q.size()), 64'd1);
    check_eq("zero_nwr", 64'(wr_q.size()), 64'd0);
    check_eq("zero_rdy", 64'(rdy_n), 64'd0);

    // Clamp: len=31 on a 16-entry memory
    start_xfer(5'd31, 20, 0, 1, 'h100);
    wait_done(80);
    repeat (2) tick();
    check_eq("clamp_nwr", 64'(wr_q.size()), 64'd16);
    check_eq("clamp_beats", 64'(beats), 64'd16);
    check_eq("clamp_left", 64'(src_q.size()), 64'd4);
    check_eq("clamp_done_cyc", 64'(first_done()), 64'd49);
    check_eq("clamp_mem0", 64'(mem[0]), 64'h100);
    check_eq("clamp_mem15", 64'(mem[15]), 64'h10F);
    src_q.delete();

    // Reset in the WRITE cycle of element 3
    start_xfer(5'd8, 8, 0, 1, 'h200);
    repeat (10) tick();
    check_eq("rmid_wr_en", 64'(mem_write_en), 64'd1);
    check_eq("rmid_wr_addr", 64'(mem_addr0), 64'd3);
    reset = 1'b1;
    src_q.delete();
    tick();
    reset = 1'b0;
    check_eq("rmid_done", 64'(done), 64'd0);
    check_eq("rmid_in_ready", 64'(in_ready), 64'd0);
    check_eq("rmid_write_en", 64'(mem_write_en), 64'd0);
    check_eq("rmid_addr", 64'(mem_addr0), 64'd0);
    check_eq("rmid_wdata", 64'(mem_write_data), 64'd0);
    repeat (4) tick();
    check_eq("rmid_no_done", 64'(done_q.size()), 64'd0);
    check_eq("rmid_sb_empty", 64'(sb_q.size()), 64'd0);
    for (int i = 0; i < 3; i++) check_eq("rmid_mem_kept", 64'(mem[i]), 64'('h200 + i));
    start_xfer(5'd2, 2, 0, 1, 'h300);
    wait_done(20);
    tick();
    check_eq("rmid2_done_cyc", 64'(first_done()), 64'd7);
    check_eq("rmid2_mem0", 64'(mem[0]), 64'h300);
    check_eq("rmid2_mem1", 64'(mem[1]), 64'h301);
    check_eq("rmid2_mem2", 64'(mem[2]), 64'h202);

    // Ignored inputs: go in ACCEPT/WAIT/DONE, mem_done in ACCEPT
    start_xfer(5'd3, 3, 2, 3, 'h600);
    for (int r = 1; r <= 30; r++) begin
      go         = (r == 2 || r == 5 || r == 22);
      len        = 5'd1;
      force_done = (r == 1);
      tick();
    end
    go         = 1'b0;
    force_done = 1'b0;
    check_eq("ign_done_cyc", 64'(first_done()), 64'd22);
    check_eq("ign_ndone", 64'(done_q.size()), 64'd1);
    check_eq("ign_nwr", 64'(wr_q.size()), 64'd3);
    check_eq("ign_rdy", 64'(rdy_n), 64'd9);
    check_eq("ign_sb_empty", 64'(sb_q.size()), 64'd0);
    check_eq("ign_mem2", 64'(mem[2]), 64'h602);

    // Back-to-back: second go in the cycle after done
    start_xfer(5'd2, 2, 0, 1, 'h400);
    wait_done(20);
    check_eq("b2b_first_done", 64'(first_done()), 64'd7);
    start_xfer(5'd3, 3, 0, 1, 'h500);
    wait_done(20);
    tick();
    check_eq("b2b_done_cyc", 64'(first_done()), 64'd10);
    check_eq("b2b_nwr", 64'(wr_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) check_eq("b2b_mem", 64'(mem[i]), 64'('h500 + i));
    check_eq("b2b_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
